// File: rtl/debug_pkg.sv
// debug_pkg: shared constants for the debug port receive framer
package debug_pkg;
  localparam logic [7:0] START_BYTE = 8'h68;
  localparam logic [7:0] CODE_WATCHDOG = 8'h65;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CODE = 3'd1;
  localparam logic [2:0] S_LEN = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CHK = 3'd4;
  localparam logic [2:0] S_OUT = 3'd5;
  localparam logic [31:0] TIMEOUT_REAL = 32'd1000000;
  localparam logic [31:0] TIMEOUT_SIM = 32'd64;
endpackage

// File: rtl/debug_rx_timer.sv
// debug_rx_timer: inter-byte timeout counter, expires when it reaches TIMEOUT-1
module debug_rx_timer #(
  parameter int TMO_W = 32,
  parameter logic [31:0] TIMEOUT = debug_pkg::TIMEOUT_REAL
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [TMO_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (clr || !en) ? '0 : cnt_q + 1'b1;
  assign expire = en && (cnt_q == TMO_W'(TIMEOUT - 32'd1));
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/debug_cmd_rx.sv
// debug_cmd_rx: hunts for frame start, parses CODE/LEN/payload/XOR checksum, emits commands and error pulses
module debug_cmd_rx
  import debug_pkg::*;
#(
  parameter logic [7:0] START_BYTE = debug_pkg::START_BYTE,
  parameter int MAX_LEN = 8,
  parameter logic [31:0] TIMEOUT = TIMEOUT_REAL,
  parameter int TMO_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_rdata,
  input  logic                 i_rready,
  output logic                 o_rreq,
  output logic                 o_cmd_valid,
  input  logic                 i_cmd_ready,
  output logic [7:0]           o_cmd_code,
  output logic [4:0]           o_cmd_len,
  output logic [8*MAX_LEN-1:0] o_cmd_data,
  output logic                 o_err_valid,
  output logic [1:0]           o_err_code
);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  logic [2:0] state_q, state_d;
  logic [7:0] code_q, code_d, chk_q, chk_d;
  logic [4:0] len_q, len_d, idx_q, idx_d;
  logic [8*MAX_LEN-1:0] buf_q, buf_d;
  logic popped_q, err_v_q, err_v_d;
  logic [1:0] err_c_q, err_c_d;
  logic rreq, tmr_en, expire, tmo;
  // one-cycle gap after each pop gives the UART time to update i_rready
  assign rreq = i_rready && (state_q != S_OUT) && !popped_q && !i_rst;
  assign tmr_en = (state_q == S_CODE) || (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
  assign tmo = expire && !rreq;
  debug_rx_timer #(.TMO_W(TMO_W), .TIMEOUT(TIMEOUT)) u_timer (
    .clk(i_clk), .rst(i_rst), .clr(rreq), .en(tmr_en), .expire(expire)
  );
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    len_d = len_q;
    idx_d = idx_q;
    chk_d = chk_q;
    buf_d = buf_q;
    err_v_d = 1'b0;
    err_c_d = err_c_q;
    case (state_q)
      S_IDLE: state_d = (rreq && i_rdata == START_BYTE) ? S_CODE : S_IDLE;
      S_CODE: if (rreq) begin
        code_d = i_rdata;
        chk_d = i_rdata;
        state_d = S_LEN;
      end
      S_LEN: if (rreq) begin
        chk_d = chk_q ^ i_rdata;
        len_d = i_rdata[4:0];
        idx_d = '0;
        state_d = (i_rdata > MAX_B) ? S_IDLE : (i_rdata == 8'd0) ? S_CHK : S_DATA;
        err_v_d = i_rdata > MAX_B;
        err_c_d = (i_rdata > MAX_B) ? ERR_LEN : err_c_q;
      end
      S_DATA: if (rreq) begin
        buf_d[8*idx_q +: 8] = i_rdata;
        chk_d = chk_q ^ i_rdata;
        idx_d = idx_q + 5'd1;
        state_d = (idx_d == len_q) ? S_CHK : S_DATA;
      end
      S_CHK: if (rreq) begin
        state_d = (i_rdata == chk_q) ? S_OUT : S_IDLE;
        err_v_d = i_rdata != chk_q;
        err_c_d = (i_rdata != chk_q) ? ERR_CHK : err_c_q;
      end
      S_OUT: state_d = i_cmd_ready ? S_IDLE : S_OUT;
      default: state_d = S_IDLE;
    endcase
    if (tmo) begin
      state_d = S_IDLE;
      err_v_d = 1'b1;
      err_c_d = ERR_TMO;
    end
    if (state_d == S_IDLE) begin
      code_d = '0;
      len_d = '0;
      idx_d = '0;
      chk_d = '0;
      buf_d = '0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      code_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      chk_q <= '0;
      buf_q <= '0;
      popped_q <= 1'b0;
      err_v_q <= 1'b0;
      err_c_q <= '0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      len_q <= len_d;
      idx_q <= idx_d;
      chk_q <= chk_d;
      buf_q <= buf_d;
      popped_q <= rreq;
      err_v_q <= err_v_d;
      err_c_q <= err_c_d;
    end
  end
  assign o_rreq = rreq;
  assign o_cmd_valid = state_q == S_OUT;
  assign o_cmd_code = code_q;
  assign o_cmd_len = len_q;
  assign o_cmd_data = buf_q;
  assign o_err_valid = err_v_q;
  assign o_err_code = err_c_q;
endmodule

// File: tb/tb_debug_cmd_rx.sv
// tb_debug_cmd_rx: directed scenario tests for the debug command receiver
module tb_debug_cmd_rx;
  logic clk = 1'b0;
  logic i_rst, i_rready, o_rreq, o_cmd_valid, i_cmd_ready, o_err_valid;
  logic [7:0] i_rdata, o_cmd_code;
  logic [4:0] o_cmd_len;
  logic [63:0] o_cmd_data;
  logic [1:0] o_err_code;
  logic manual, m_rready, s_rready, drv_pop;
  logic [7:0] m_rdata, s_rdata;
  logic [7:0] q[$];
  int errors = 0, checks = 0, cmd_cnt = 0, err_cnt = 0;
  logic [7:0] last_code;
  logic [4:0] last_len;
  logic [63:0] last_data;
  logic [1:0] last_err;

  assign i_rready = manual ? m_rready : s_rready;
  assign i_rdata = manual ? m_rdata : s_rdata;

  debug_cmd_rx #(.MAX_LEN(8), .TIMEOUT(32'd64)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_rdata(i_rdata), .i_rready(i_rready), .o_rreq(o_rreq),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready), .o_cmd_code(o_cmd_code),
    .o_cmd_len(o_cmd_len), .o_cmd_data(o_cmd_data), .o_err_valid(o_err_valid), .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  initial begin
    s_rready = 1'b0;
    s_rdata = 8'h00;
    forever begin
      @(negedge clk);
      drv_pop = o_rreq;
      if (o_cmd_valid && i_cmd_ready) begin
        cmd_cnt++;
        last_code = o_cmd_code;
        last_len = o_cmd_len;
        last_data = o_cmd_data;
      end
      if (o_err_valid) begin
        err_cnt++;
        last_err = o_err_code;
      end
      @(posedge clk);
      #1;
      if (!manual) begin
        if (drv_pop && q.size() > 0) void'(q.pop_front());
        s_rready = q.size() > 0;
        s_rdata = (q.size() > 0) ? q[0] : 8'h00;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_drain();
    int n = 0;
    while (q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() > 0) begin errors++; $display("FAIL drain: %0d bytes left, required 0", q.size()); end
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    m_rready = 1'b1;
    m_rdata = b;
    @(posedge clk);
    #1;
    m_rready = 1'b0;
  endtask

  task automatic test_reset();
    manual = 1'b1;
    m_rready = 1'b1;
    m_rdata = 8'h68;
    i_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (o_rreq !== 1'b0) begin errors++; $display("FAIL reset_rreq: got %b want 0", o_rreq); end
    checks++; if (o_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_cmd_valid); end
    checks++; if (o_err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid: got %b want 0", o_err_valid); end
    checks++; if (o_err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d want 0", o_err_code); end
    checks++; if (o_cmd_code !== 8'h00 || o_cmd_len !== 5'd0) begin errors++; $display("FAIL reset_code_len: got %h/%0d want 00/0", o_cmd_code, o_cmd_len); end
    checks++; if (o_cmd_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", o_cmd_data); end
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    m_rready = 1'b0;
    manual = 1'b0;
  endtask

  task automatic test_basic();
    int c0 = cmd_cnt, e0 = err_cnt;
    i_cmd_ready = 1'b1;
    q.push_back(8'h68); q.push_back(8'h10); q.push_back(8'h02);
    q.push_back(8'hAA); q.push_back(8'h55); q.push_back(8'hED);
    wait_drain();
    checks++; if (cmd_cnt - c0 !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", cmd_cnt - c0); end
    checks++; if (last_code !== 8'h10) begin errors++; $display("FAIL basic_code: got %h want 10", last_code); end
    checks++; if (last_len !== 5'd2) begin errors++; $display("FAIL basic_len: got %0d want 2", last_len); end
    checks++; if (last_data !== 64'h55AA) begin errors++; $display("FAIL basic_data: got %h want 55aa", last_data); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL basic_noerr: got %0d want %0d", err_cnt, e0); end
  endtask

  task automatic test_garbage();
    int c0 = cmd_cnt, e0 = err_cnt;
    q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h68);
    q.push_back(8'h65); q.push_back(8'h00); q.push_back(8'h65);
    wait_drain();
    checks++; if (cmd_cnt - c0 !== 1) begin errors++; $display("FAIL garbage_count: got %0d want 1", cmd_cnt - c0); end
    checks++; if (last_code !== 8'h65 || last_len !== 5'd0) begin errors++; $display("FAIL garbage_code_len: got %h/%0d want 65/0", last_code, last_len); end
    checks++; if (last_data !== 64'h0) begin errors++; $display("FAIL garbage_data: got %h want 0", last_data); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL garbage_noerr: got %0d want %0d", err_cnt, e0); end
  endtask

  task automatic test_bad_chk();
    int c0 = cmd_cnt, e0 = err_cnt;
    q.push_back(8'h68); q.push_back(8'h10); q.push_back(8'h02);
    q.push_back(8'hAA); q.push_back(8'h55); q.push_back(8'hEE);
    q.push_back(8'h68); q.push_back(8'h65); q.push_back(8'h00); q.push_back(8'h65);
    wait_drain();
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL badchk_errcount: got %0d want 1", err_cnt - e0); end
    checks++; if (last_err !== 2'd2) begin errors++; $display("FAIL badchk_code: got %0d want 2", last_err); end
    checks++; if (cmd_cnt - c0 !== 1) begin errors++; $display("FAIL badchk_cmdcount: got %0d want 1", cmd_cnt - c0); end
    checks++; if (last_code !== 8'h65) begin errors++; $display("FAIL badchk_next: got %h want 65", last_code); end
  endtask

  task automatic test_len_err();
    int c0 = cmd_cnt, e0 = err_cnt;
    manual = 1'b1;
    m_rready = 1'b0;
    pop_byte(8'h68); pop_byte(8'h10); pop_byte(8'h09);
    @(negedge clk);
    checks++; if (o_err_valid !== 1'b1 || o_err_code !== 2'd1) begin errors++; $display("FAIL len_pulse: got %b/%0d want 1/1", o_err_valid, o_err_code); end
    @(negedge clk);
    checks++; if (o_err_valid !== 1'b0 || o_err_code !== 2'd1) begin errors++; $display("FAIL len_hold: got %b/%0d want 0/1", o_err_valid, o_err_code); end
    pop_byte(8'h01); pop_byte(8'h02);
    pop_byte(8'h68); pop_byte(8'h65); pop_byte(8'h00); pop_byte(8'h65);
    repeat (3) @(negedge clk);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL len_errcount: got %0d want 1", err_cnt - e0); end
    checks++; if (cmd_cnt - c0 !== 1 || last_code !== 8'h65) begin errors++; $display("FAIL len_next: got %0d/%h want 1/65", cmd_cnt - c0, last_code); end
    manual = 1'b0;
  endtask

  task automatic test_back_to_back();
    int c0 = cmd_cnt, n = 0;
    i_cmd_ready = 1'b0;
    q.push_back(8'h68); q.push_back(8'h10); q.push_back(8'h01); q.push_back(8'h33); q.push_back(8'h22);
    q.push_back(8'h68); q.push_back(8'h65); q.push_back(8'h00); q.push_back(8'h65);
    while (o_cmd_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (o_cmd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", o_cmd_valid); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (o_rreq !== 1'b0 || o_cmd_valid !== 1'b1 || o_cmd_data !== 64'h33 || o_cmd_code !== 8'h10 || i_rready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_stall: rreq=%b valid=%b data=%h code=%h rready=%b want 0 1 33 10 1", o_rreq, o_cmd_valid, o_cmd_data, o_cmd_code, i_rready);
      end
    end
    @(posedge clk);
    #1;
    i_cmd_ready = 1'b1;
    @(negedge clk);
    checks++; if (o_cmd_valid !== 1'b1 || o_rreq !== 1'b0) begin errors++; $display("FAIL b2b_accept: valid=%b rreq=%b want 1 0", o_cmd_valid, o_rreq); end
    @(negedge clk);
    checks++; if (o_cmd_valid !== 1'b0 || o_rreq !== 1'b1) begin errors++; $display("FAIL b2b_resume: valid=%b rreq=%b want 0 1", o_cmd_valid, o_rreq); end
    wait_drain();
    checks++; if (cmd_cnt - c0 !== 2 || last_code !== 8'h65) begin errors++; $display("FAIL b2b_second: got %0d/%h want 2/65", cmd_cnt - c0, last_code); end
  endtask

  task automatic test_reset_mid();
    int c0 = cmd_cnt, e0 = err_cnt;
    q.push_back(8'h68); q.push_back(8'h10); q.push_back(8'h04); q.push_back(8'h01);
    q.push_back(8'h02); q.push_back(8'h03); q.push_back(8'h04); q.push_back(8'h10);
    repeat (10) @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(negedge clk);
    checks++; if (o_rreq !== 1'b0) begin errors++; $display("FAIL rstmid_rreq: got %b want 0", o_rreq); end
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    q.delete();
    @(negedge clk);
    checks++; if (o_cmd_valid !== 1'b0 || o_err_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valids: got %b/%b want 0/0", o_cmd_valid, o_err_valid); end
    checks++; if (o_err_code !== 2'd0) begin errors++; $display("FAIL rstmid_err_code: got %0d want 0", o_err_code); end
    checks++; if (o_cmd_data !== 64'h0 || o_cmd_code !== 8'h0 || o_cmd_len !== 5'd0) begin errors++; $display("FAIL rstmid_cmd: got %h/%h/%0d want 0/0/0", o_cmd_data, o_cmd_code, o_cmd_len); end
    repeat (20) @(negedge clk);
    checks++; if (cmd_cnt !== c0 || err_cnt !== e0) begin errors++; $display("FAIL rstmid_silent: got cmd+%0d err+%0d want 0 0", cmd_cnt - c0, err_cnt - e0); end
  endtask

  task automatic test_timeout();
    int e0 = err_cnt;
    manual = 1'b1;
    m_rready = 1'b0;
    pop_byte(8'h68); pop_byte(8'h10);
    repeat (63) @(posedge clk);
    @(negedge clk);
    checks++; if (o_err_valid !== 1'b0 || err_cnt !== e0) begin errors++; $display("FAIL tmo_early: valid=%b count+%0d want 0 0", o_err_valid, err_cnt - e0); end
    @(negedge clk);
    checks++; if (o_err_valid !== 1'b1 || o_err_code !== 2'd3) begin errors++; $display("FAIL tmo_pulse: got %b/%0d want 1/3", o_err_valid, o_err_code); end
    @(negedge clk);
    checks++; if (o_err_valid !== 1'b0) begin errors++; $display("FAIL tmo_once: got %b want 0", o_err_valid); end
    e0 = err_cnt;
    pop_byte(8'h68); pop_byte(8'h10);
    repeat (62) @(posedge clk);
    pop_byte(8'h02);
    @(negedge clk);
    @(negedge clk);
    checks++; if (o_err_valid !== 1'b0 || err_cnt !== e0) begin errors++; $display("FAIL tmo_race: valid=%b count+%0d want 0 0", o_err_valid, err_cnt - e0); end
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    manual = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_cmd_ready = 1'b0;
    manual = 1'b1;
    m_rready = 1'b0;
    m_rdata = 8'h00;
    test_reset();
    test_basic();
    test_garbage();
    test_bad_chk();
    test_len_err();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
